// File: rtl/psw_pkg.sv
// Shared constants and types for the password store datapath.
package psw_pkg;

  localparam int PSW_DIGIT_W = 4;
  localparam int PSW_MAX_LEN = 8;
  localparam int PSW_LEN_W   = $clog2(PSW_MAX_LEN + 1);
  localparam int PSW_BCD_MAX = 9;

  typedef logic [PSW_MAX_LEN*PSW_DIGIT_W-1:0] psw_digits_t;

endpackage

// File: rtl/psw_store_if.sv
// Command/status bundle between the doorlock control unit (master) and psw_store (slave).
interface psw_store_if;
  import psw_pkg::*;

  // No valid/ready: each command is a level sampled on a clock edge, one command per
  // high cycle; status is combinational from registered state and valid one edge later.
  logic [PSW_DIGIT_W-1:0] digit_i;
  logic                   mem_rst_i;
  logic                   mem_sl_i;
  logic                   buff_rst_i;
  logic                   buff_sl_i;
  logic                   mem_limit_o;
  logic                   buff_limit_o;
  logic                   same_o;
  logic                   master_same_o;
  logic [PSW_LEN_W-1:0]   mem_len_o;
  logic [PSW_LEN_W-1:0]   buff_len_o;

  modport master (
    output digit_i, mem_rst_i, mem_sl_i, buff_rst_i, buff_sl_i,
    input  mem_limit_o, buff_limit_o, same_o, master_same_o, mem_len_o, buff_len_o
  );

  modport slave (
    input  digit_i, mem_rst_i, mem_sl_i, buff_rst_i, buff_sl_i,
    output mem_limit_o, buff_limit_o, same_o, master_same_o, mem_len_o, buff_len_o
  );

endinterface

// File: rtl/psw_shift_reg.sv
// Digit shift register with saturating length counter; clear beats shift, non-BCD digits are dropped.
module psw_shift_reg
  import psw_pkg::*;
#(
  parameter int DIGIT_W = PSW_DIGIT_W,
  parameter int MAX_LEN = PSW_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [DIGIT_W-1:0]         digit_i,
  input  logic                       rst_i,
  input  logic                       sl_i,
  output logic [MAX_LEN*DIGIT_W-1:0] data_o,
  output logic [LEN_W-1:0]           len_o,
  output logic                       limit_o
);

  localparam logic [DIGIT_W-1:0] BCD_MAX  = DIGIT_W'(PSW_BCD_MAX);
  localparam logic [LEN_W-1:0]   LEN_FULL = LEN_W'(MAX_LEN);

  logic [MAX_LEN*DIGIT_W-1:0] data_q, data_d;
  logic [LEN_W-1:0]           len_q, len_d;
  logic                       full;

  assign full = (len_q == LEN_FULL);

  always_comb begin
    data_d = data_q;
    len_d  = len_q;
    if (rst_i) begin
      data_d = '0;
      len_d  = '0;
    end else if (sl_i && !full && (digit_i <= BCD_MAX)) begin
      data_d = {data_q[(MAX_LEN-1)*DIGIT_W-1:0], digit_i};
      len_d  = len_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_q <= '0;
      len_q  <= '0;
    end else begin
      data_q <= data_d;
      len_q  <= len_d;
    end
  end

  assign data_o  = data_q;
  assign len_o   = len_q;
  assign limit_o = full;

endmodule

// File: rtl/psw_store.sv
// Password store: stored (mem) and attempt (buff) digit registers plus comparators.
// Master password compare is built only when PSW_MASTER_EN is defined.
module psw_store
  import psw_pkg::*;
#(
  parameter int                           DIGIT_W    = PSW_DIGIT_W,
  parameter int                           MAX_LEN    = PSW_MAX_LEN,
  parameter int                           MASTER_LEN = PSW_MAX_LEN,
  parameter logic [MAX_LEN*DIGIT_W-1:0]   MASTER_PSW = 32'h1234_5678
) (
  input  logic       clk_i,
  input  logic       reset_i,
  psw_store_if.slave bus
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int REG_W = MAX_LEN * DIGIT_W;

  // Master password must fit in the register and be right-aligned.
  if (MASTER_LEN < 1 || MASTER_LEN > MAX_LEN) begin : g_bad_master_len
    $error("psw_store: MASTER_LEN out of range");
  end
  if ((MASTER_PSW >> (MASTER_LEN * DIGIT_W)) != '0) begin : g_bad_master_psw
    $error("psw_store: MASTER_PSW has digits above MASTER_LEN");
  end

  logic [REG_W-1:0] mem_data, buff_data;
  logic [LEN_W-1:0] mem_len, buff_len;
  logic             mem_limit, buff_limit;

  psw_shift_reg #(.DIGIT_W(DIGIT_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_mem (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .digit_i (bus.digit_i),
    .rst_i   (bus.mem_rst_i),
    .sl_i    (bus.mem_sl_i),
    .data_o  (mem_data),
    .len_o   (mem_len),
    .limit_o (mem_limit)
  );

  psw_shift_reg #(.DIGIT_W(DIGIT_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_buff (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .digit_i (bus.digit_i),
    .rst_i   (bus.buff_rst_i),
    .sl_i    (bus.buff_sl_i),
    .data_o  (buff_data),
    .len_o   (buff_len),
    .limit_o (buff_limit)
  );

  // An empty stored password never matches.
  assign bus.same_o = (mem_len != '0) && (mem_len == buff_len) && (mem_data == buff_data);

`ifdef PSW_MASTER_EN
  assign bus.master_same_o = (buff_len == LEN_W'(MASTER_LEN)) &&
    (buff_data[MASTER_LEN*DIGIT_W-1:0] == MASTER_PSW[MASTER_LEN*DIGIT_W-1:0]);
`else
  assign bus.master_same_o = 1'b0;
`endif

  assign bus.mem_limit_o  = mem_limit;
  assign bus.buff_limit_o = buff_limit;
  assign bus.mem_len_o    = mem_len;
  assign bus.buff_len_o   = buff_len;

endmodule

// File: tb/tb_psw_store.sv
// Bench for psw_store: digit-queue reference model checked every cycle plus directed literal checks.
module tb_psw_store;
  import psw_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  psw_store_if bus ();

  psw_store dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef PSW_MASTER_EN
  localparam bit MASTER_ON = 1'b1;
`else
  localparam bit MASTER_ON = 1'b0;
`endif

  // ---------------- reference model ----------------
  // Each register is simply the list of accepted digits in entry order.
  logic [PSW_DIGIT_W-1:0] mem_q[$];
  logic [PSW_DIGIT_W-1:0] buff_q[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q.delete();
      buff_q.delete();
    end else begin
      if (bus.mem_rst_i) mem_q.delete();
      else if (bus.mem_sl_i && mem_q.size() < PSW_MAX_LEN && bus.digit_i <= 9)
        mem_q.push_back(bus.digit_i);
      if (bus.buff_rst_i) buff_q.delete();
      else if (bus.buff_sl_i && buff_q.size() < PSW_MAX_LEN && bus.digit_i <= 9)
        buff_q.push_back(bus.digit_i);
    end
  end

  function automatic bit model_same();
    if (mem_q.size() == 0 || mem_q.size() != buff_q.size()) return 1'b0;
    for (int i = 0; i < mem_q.size(); i++)
      if (mem_q[i] != buff_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Master password 0x12345678 is the digit sequence 1..8 in entry order.
  function automatic bit model_master();
    if (!MASTER_ON || buff_q.size() != 8) return 1'b0;
    for (int i = 0; i < 8; i++)
      if (int'(buff_q[i]) != i + 1) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("mem_len",     int'(bus.mem_len_o),     mem_q.size());
    chk("buff_len",    int'(bus.buff_len_o),    buff_q.size());
    chk("mem_limit",   int'(bus.mem_limit_o),   int'(mem_q.size() == PSW_MAX_LEN));
    chk("buff_limit",  int'(bus.buff_limit_o),  int'(buff_q.size() == PSW_MAX_LEN));
    chk("same",        int'(bus.same_o),        int'(model_same()));
    chk("master_same", int'(bus.master_same_o), int'(model_master()));
  end

  // ---------------- driver tasks ----------------
  task automatic cmd(input bit mr, input bit ms, input bit br, input bit bs, input int d);
    bus.mem_rst_i  = mr;
    bus.mem_sl_i   = ms;
    bus.buff_rst_i = br;
    bus.buff_sl_i  = bs;
    bus.digit_i    = PSW_DIGIT_W'(d);
    @(posedge clk);
    #1;
    bus.mem_rst_i  = 1'b0;
    bus.mem_sl_i   = 1'b0;
    bus.buff_rst_i = 1'b0;
    bus.buff_sl_i  = 1'b0;
  endtask

  task automatic mem_seq(input int n, input logic [31:0] digs);
    for (int i = n - 1; i >= 0; i--) cmd(0, 1, 0, 0, int'((digs >> (4 * i)) & 32'hF));
  endtask

  task automatic buff_seq(input int n, input logic [31:0] digs);
    for (int i = n - 1; i >= 0; i--) cmd(0, 0, 0, 1, int'((digs >> (4 * i)) & 32'hF));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_len"},  int'(bus.mem_len_o),  0);
    chk({tag, "_buff_len"}, int'(bus.buff_len_o), 0);
    chk({tag, "_limits"},   int'({bus.mem_limit_o, bus.buff_limit_o}), 0);
    chk({tag, "_same"},     int'({bus.same_o, bus.master_same_o}), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.digit_i = '0;
    bus.mem_rst_i = 1'b0;
    bus.mem_sl_i = 1'b0;
    bus.buff_rst_i = 1'b0;
    bus.buff_sl_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;

    // Async reset mid-run: outputs drop before any clock edge.
    mem_seq(3, 32'h0000_0123);
    buff_seq(2, 32'h0000_0045);
    #2 reset = 1'b1;
    #1 chk_all_zero("async_reset");
    @(posedge clk);
    #1 reset = 1'b0;
    buff_seq(1, 32'h3);
    chk("post_reset_buff_len", int'(bus.buff_len_o), 1);
    chk("post_reset_same", int'(bus.same_o), 0);

    // Matching entry, then one extra digit breaks it.
    cmd(1, 0, 1, 0, 0);
    mem_seq(4, 32'h0000_1234);
    buff_seq(4, 32'h0000_1234);
    chk("match_mem_len", int'(bus.mem_len_o), 4);
    chk("match_buff_len", int'(bus.buff_len_o), 4);
    chk("match_same", int'(bus.same_o), 1);
    buff_seq(1, 32'h5);
    chk("extra_digit_same", int'(bus.same_o), 0);

    // Order and length mismatches.
    cmd(0, 0, 1, 0, 0);
    buff_seq(4, 32'h0000_1243);
    chk("order_same", int'(bus.same_o), 0);
    cmd(0, 0, 1, 0, 0);
    buff_seq(3, 32'h0000_0123);
    chk("short_same", int'(bus.same_o), 0);

    // Saturation: 9 shifts of 7, the last must be ignored.
    cmd(1, 0, 1, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      cmd(0, 1, 0, 0, 7);
      chk("sat_mem_limit", int'(bus.mem_limit_o), (i >= 8) ? 1 : 0);
      chk("sat_mem_len", int'(bus.mem_len_o), (i >= 8) ? 8 : i);
    end
    buff_seq(8, 32'h7777_7777);
    chk("sat_contents_same", int'(bus.same_o), 1);
    chk("sat_buff_limit", int'(bus.buff_limit_o), 1);

    // rst beats sl; non-BCD digit is dropped.
    cmd(0, 0, 1, 1, 5);
    chk("rst_sl_buff_len", int'(bus.buff_len_o), 0);
    buff_seq(2, 32'h0000_0012);
    cmd(0, 0, 0, 1, 4'hA);
    chk("bad_digit_buff_len", int'(bus.buff_len_o), 2);
    cmd(0, 1, 0, 1, 4'hF);
    chk("bad_digit_mem_len", int'(bus.mem_len_o), 8);

    // Master password.
    cmd(0, 0, 1, 0, 0);
    buff_seq(8, 32'h1234_5678);
    chk("master_hit", int'(bus.master_same_o), MASTER_ON ? 1 : 0);
    cmd(0, 0, 1, 0, 0);
    buff_seq(8, 32'h1234_5679);
    chk("master_miss", int'(bus.master_same_o), 0);

    // Random commands; small digit alphabet so matches actually occur.
    for (int i = 0; i < 3000; i++) begin
      int d;
      d = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 2);
      if ($urandom_range(0, 40) == 0) d = $urandom_range(0, 9);
      cmd($urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 0, d);
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
